game_move: RTL and testbench

//  Move engine for Sokoban; produces candidate next states consumed by the state-select/undo stage.

---
 rtl/sokoban_pkg.sv | 58 +++++
 rtl/game_player_locate.sv | 32 +++
 rtl/game_move.sv | 165 ++++++++++++++++
 tb/tb_game_move.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sokoban_pkg.sv
// Shared types, grid geometry and the neighbour helper for the Sokoban move engine.
package sokoban_pkg;

    localparam int GRID_W  = 8;
    localparam int GRID_H  = 8;
    localparam int NCELL   = GRID_W * GRID_H;
    localparam int STEP_W  = 6;
    localparam int STATE_W = 2 * NCELL + STEP_W;

    typedef enum logic [1:0] {
        CELL_FLOOR  = 2'b00,
        CELL_WALL   = 2'b01,
        CELL_BOX    = 2'b10,
        CELL_PLAYER = 2'b11
    } cell_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_MAN  = 2'd1;
    localparam logic [1:0] SEL_BOX  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EVAL,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       off_grid;
        logic [5:0] idx;
    } nbr_t;

    // Off-grid neighbours are flagged so the caller can treat them as wall.
    function automatic nbr_t neighbour(input logic [5:0] idx, input logic [1:0] dir);
        int   row;
        int   col;
        nbr_t n;
        row        = int'(idx) / GRID_W;
        col        = int'(idx) % GRID_W;
        n.off_grid = 1'b0;
        case (dir)
            DIR_UP:    if (row == 0)          n.off_grid = 1'b1; else row = row - 1;
            DIR_DOWN:  if (row == GRID_H - 1) n.off_grid = 1'b1; else row = row + 1;
            DIR_LEFT:  if (col == 0)          n.off_grid = 1'b1; else col = col - 1;
            default:   if (col == GRID_W - 1) n.off_grid = 1'b1; else col = col + 1;
        endcase
        n.idx = 6'(row * GRID_W + col);
        return n;
    endfunction

endpackage

// File: rtl/game_player_locate.sv
// Player scan: walks the snapshot one cell per cycle and reports the first player cell.
module game_player_locate
    import sokoban_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_en,
    input  logic [127:0] i_cells,
    output logic         o_found,
    output logic [5:0]   o_pos,
    output logic         o_not_found
);

    logic [5:0] r_idx;
    logic       w_is_player;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + 6'd1;
        end
    end

    assign w_is_player = (i_cells[{r_idx, 1'b0} +: 2] == CELL_PLAYER);
    assign o_found     = i_en && w_is_player;
    assign o_pos       = r_idx;
    assign o_not_found = i_en && !w_is_player && (r_idx == 6'(NCELL - 1));

endmodule

// File: rtl/game_move.sv
// Sokoban move engine: snapshot, scan for player, resolve man move / box push / blocked.
// Optional GAME_WIN_DETECT_EN adds goal_map and a sticky win flag on box pushes.
module game_move
    import sokoban_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] game_state,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_dir,
`ifdef GAME_WIN_DETECT_EN
    input  logic [63:0]  goal_map,
`endif
    output logic         cmd_ready,
    output logic [133:0] game_state_mm,
    output logic [133:0] game_state_bm,
    output logic [1:0]   sel,
    output logic         game_state_en,
    output logic         move_blocked,
    output logic         win
);

    state_e         r_state;
    state_e         w_next;
    logic [133:0]   r_snap;
    logic [1:0]     r_dir;
    logic [5:0]     r_pos;
    logic           r_no_player;
    logic [133:0]   r_mm;
    logic [133:0]   r_bm;
    logic [1:0]     r_sel;
    logic           r_en;
    logic           r_blk;

    logic           w_accept;
    logic           w_found;
    logic           w_not_found;
    logic [5:0]     w_pos;
    nbr_t           w_n1;
    nbr_t           w_n2;
    logic [1:0]     w_c1;
    logic [1:0]     w_c2;
    logic           w_man_ok;
    logic           w_box_ok;
    logic [5:0]     w_step_next;
    logic [127:0]   w_cells_mm;
    logic [127:0]   w_cells_bm;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    game_player_locate u_locate (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept),
        .i_en        (r_state == S_SCAN),
        .i_cells     (r_snap[127:0]),
        .o_found     (w_found),
        .o_pos       (w_pos),
        .o_not_found (w_not_found)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SCAN;
            S_SCAN:  if (w_found || w_not_found) w_next = S_EVAL;
            S_EVAL:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: snapshot/position registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap <= game_state;
            r_dir  <= cmd_dir;
        end
        if (r_state == S_SCAN && (w_found || w_not_found)) begin
            r_pos       <= w_pos;
            r_no_player <= w_not_found;
        end
    end

    assign w_n1        = neighbour(r_pos, r_dir);
    assign w_n2        = neighbour(w_n1.idx, r_dir);
    assign w_c1        = r_snap[{w_n1.idx, 1'b0} +: 2];
    assign w_c2        = r_snap[{w_n2.idx, 1'b0} +: 2];
    assign w_man_ok    = !r_no_player && !w_n1.off_grid && (w_c1 == CELL_FLOOR);
    assign w_box_ok    = !r_no_player && !w_n1.off_grid && (w_c1 == CELL_BOX)
                         && !w_n2.off_grid && (w_c2 == CELL_FLOOR);
    assign w_step_next = (r_snap[133:128] == 6'h3F) ? 6'h3F : r_snap[133:128] + 6'd1;

    always_comb begin
        w_cells_mm = r_snap[127:0];
        w_cells_mm[{r_pos, 1'b0} +: 2]    = CELL_FLOOR;
        w_cells_mm[{w_n1.idx, 1'b0} +: 2] = CELL_PLAYER;
        w_cells_bm = w_cells_mm;
        w_cells_bm[{w_n2.idx, 1'b0} +: 2] = CELL_BOX;
    end

`ifdef GAME_WIN_DETECT_EN
    logic [63:0] w_box_bits;
    logic        r_win;

    always_comb begin
        for (int i = 0; i < NCELL; i++) begin
            w_box_bits[i] = (w_cells_bm[2*i +: 2] == CELL_BOX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= 1'b0;
        end else if (r_state == S_EVAL && w_box_ok) begin
            r_win <= r_win | (&(~goal_map | w_box_bits));
        end
    end

    assign win = r_win;
`else
    assign win = 1'b0;
`endif

    // Strobes are registered on the EVAL edge so they are high for exactly the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mm  <= '0;
            r_bm  <= '0;
            r_sel <= SEL_NONE;
            r_en  <= 1'b0;
            r_blk <= 1'b0;
        end else begin
            r_en  <= 1'b0;
            r_blk <= 1'b0;
            if (r_state == S_EVAL) begin
                if (w_man_ok) begin
                    r_mm  <= {w_step_next, w_cells_mm};
                    r_sel <= SEL_MAN;
                    r_en  <= 1'b1;
                end else if (w_box_ok) begin
                    r_bm  <= {w_step_next, w_cells_bm};
                    r_sel <= SEL_BOX;
                    r_en  <= 1'b1;
                end else begin
                    r_sel <= SEL_NONE;
                    r_blk <= 1'b1;
                end
            end
        end
    end

    assign game_state_mm = r_mm;
    assign game_state_bm = r_bm;
    assign sel           = r_sel;
    assign game_state_en = r_en;
    assign move_blocked  = r_blk;

endmodule

// File: tb/tb_game_move.sv
// Scoreboard bench for game_move: a row/col reference model predicts each outcome and latency.
module tb_game_move;

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] game_state;
    logic         cmd_valid;
    logic [1:0]   cmd_dir;
    logic         cmd_ready;
    logic [133:0] game_state_mm;
    logic [133:0] game_state_bm;
    logic [1:0]   sel;
    logic         game_state_en;
    logic         move_blocked;
    logic         win;
    logic [63:0]  goal = '1;
`ifdef GAME_WIN_DETECT_EN
    logic [63:0]  goal_map;
    assign goal_map = goal;
`endif

    always #5 clk = ~clk;

    game_move dut (
        .clk           (clk),
        .rst           (rst),
        .game_state    (game_state),
        .cmd_valid     (cmd_valid),
        .cmd_dir       (cmd_dir),
`ifdef GAME_WIN_DETECT_EN
        .goal_map      (goal_map),
`endif
        .cmd_ready     (cmd_ready),
        .game_state_mm (game_state_mm),
        .game_state_bm (game_state_bm),
        .sel           (sel),
        .game_state_en (game_state_en),
        .move_blocked  (move_blocked),
        .win           (win)
    );

    typedef struct {
        int           kind;   // 0 blocked, 1 man move, 2 box push
        int           lat;
        logic [133:0] mm;
        logic [133:0] bm;
        logic [1:0]   sel;
        logic         win;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [133:0] exp_mm_prev = '0;
    logic [133:0] exp_bm_prev = '0;
    logic         exp_win     = 1'b0;

    function automatic logic [1:0] cell_of(input logic [133:0] st, input int i);
        logic [133:0] t;
        t = st >> (2 * i);
        return t[1:0];
    endfunction

    function automatic logic [133:0] set_cell(input logic [133:0] st, input int i, input logic [1:0] v);
        logic [133:0] m;
        logic [133:0] d;
        m = 134'h3 << (2 * i);
        d = {132'b0, v} << (2 * i);
        return (st & ~m) | d;
    endfunction

    function automatic logic [133:0] floor_grid(input int player, input logic [5:0] step);
        logic [133:0] st;
        st = '0;
        st[133:128] = step;
        if (player >= 0) st = set_cell(st, player, 2'b11);
        return st;
    endfunction

    function automatic void model(input logic [133:0] st, input logic [1:0] dir,
                                  output int kind, output int lat, output logic [133:0] nxt);
        int p;
        int r, c, r1, c1, r2, c2, dr, dc, n1, n2;
        logic [5:0] stp;
        p = -1; dr = 0; dc = 0; kind = 0; nxt = st;
        for (int i = 0; i < 64; i++) if (p < 0 && cell_of(st, i) == 2'b11) p = i;
        if (p < 0) begin
            lat = 65;
            return;
        end
        lat = p + 2;
        r = p / 8; c = p % 8;
        case (dir)
            2'd0: dr = -1;
            2'd1: dr = 1;
            2'd2: dc = -1;
            default: dc = 1;
        endcase
        r1 = r + dr; c1 = c + dc; r2 = r1 + dr; c2 = c1 + dc;
        if (r1 >= 0 && r1 < 8 && c1 >= 0 && c1 < 8) begin
            n1 = r1 * 8 + c1;
            if (cell_of(st, n1) == 2'b00) begin
                kind = 1;
                nxt  = set_cell(set_cell(st, p, 2'b00), n1, 2'b11);
            end else if (cell_of(st, n1) == 2'b10 && r2 >= 0 && r2 < 8 && c2 >= 0 && c2 < 8) begin
                n2 = r2 * 8 + c2;
                if (cell_of(st, n2) == 2'b00) begin
                    kind = 2;
                    nxt  = set_cell(set_cell(set_cell(st, p, 2'b00), n1, 2'b11), n2, 2'b10);
                end
            end
        end
        if (kind != 0) begin
            stp = st[133:128];
            nxt[133:128] = (stp == 6'd63) ? 6'd63 : stp + 6'd1;
        end
    endfunction

    task automatic issue(input logic [133:0] st, input logic [1:0] dir, input bit push);
        exp_t         e;
        int           kind, lat, n;
        logic [133:0] nxt;
        logic [63:0]  boxes;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        game_state = st; cmd_dir = dir; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        game_state = ~st;
        if (!push) return;
        model(st, dir, kind, lat, nxt);
        if (kind == 1) exp_mm_prev = nxt;
        if (kind == 2) begin
            exp_bm_prev = nxt;
`ifdef GAME_WIN_DETECT_EN
            for (int i = 0; i < 64; i++) boxes[i] = (cell_of(nxt, i) == 2'b10);
            exp_win = exp_win | (&(~goal | boxes));
`else
            boxes = '0;
`endif
        end
        e.kind = kind; e.lat = lat; e.mm = exp_mm_prev; e.bm = exp_bm_prev;
        e.sel  = 2'(kind); e.win = exp_win;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   n;
        bit   seen;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1; n++;
            if (game_state_en || move_blocked) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no strobe within %0d cycles, required at %0d", name, n, e.lat);
            return;
        end
        checks++;
        if (n !== e.lat) begin
            errors++; $display("FAIL %s_latency: got %0d required %0d", name, n, e.lat);
        end
        checks++;
        if (game_state_en !== (e.kind != 0) || move_blocked !== (e.kind == 0)) begin
            errors++;
            $display("FAIL %s_strobe: en=%b blocked=%b required kind %0d", name, game_state_en, move_blocked, e.kind);
        end
        checks++;
        if (sel !== e.sel) begin
            errors++; $display("FAIL %s_sel: got %0d required %0d", name, sel, e.sel);
        end
        checks++;
        if (game_state_mm !== e.mm) begin
            errors++; $display("FAIL %s_mm: got %h required %h", name, game_state_mm, e.mm);
        end
        checks++;
        if (game_state_bm !== e.bm) begin
            errors++; $display("FAIL %s_bm: got %h required %h", name, game_state_bm, e.bm);
        end
        checks++;
        if (win !== e.win) begin
            errors++; $display("FAIL %s_win: got %b required %b", name, win, e.win);
        end
        @(posedge clk); #1;
        checks++;
        if (game_state_en !== 1'b0 || move_blocked !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_one_shot: en=%b blocked=%b ready=%b required 0/0/1", name, game_state_en, move_blocked, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'd0; game_state = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || game_state_en !== 1'b0 || move_blocked !== 1'b0 || sel !== 2'd0 ||
            game_state_mm !== '0 || game_state_bm !== '0 || win !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b en=%b blk=%b sel=%0d win=%b mm=%h bm=%h required 1/0/0/0/0/0/0",
                     cmd_ready, game_state_en, move_blocked, sel, win, game_state_mm, game_state_bm);
        end
        rst = 1'b0;
        exp_mm_prev = '0; exp_bm_prev = '0; exp_win = 1'b0;
    endtask

    task automatic test_man_move();
        issue(floor_grid(0, 6'd0), 2'd3, 1'b1);
        drain("man_right_idx0");
        checks++;
        if (game_state_mm[1:0] !== 2'b00 || game_state_mm[3:2] !== 2'b11 || game_state_mm[133:128] !== 6'd1) begin
            errors++;
            $display("FAIL man_cells: cell0=%b cell1=%b step=%0d required 00/11/1",
                     game_state_mm[1:0], game_state_mm[3:2], game_state_mm[133:128]);
        end
        issue(floor_grid(27, 6'd4), 2'd0, 1'b1);  drain("man_up");
        issue(floor_grid(27, 6'd9), 2'd1, 1'b1);  drain("man_down");
        issue(floor_grid(27, 6'd17), 2'd2, 1'b1); drain("man_left");
    endtask

    task automatic test_box_push();
        logic [133:0] st;
        st = set_cell(floor_grid(9, 6'd3), 10, 2'b10);
        issue(st, 2'd3, 1'b1);
        drain("box_right");
        checks++;
        if (cell_of(game_state_bm, 9) !== 2'b00 || cell_of(game_state_bm, 10) !== 2'b11 || cell_of(game_state_bm, 11) !== 2'b10) begin
            errors++;
            $display("FAIL box_cells: 9/10/11=%b/%b/%b required 00/11/10",
                     cell_of(game_state_bm, 9), cell_of(game_state_bm, 10), cell_of(game_state_bm, 11));
        end
        st = set_cell(floor_grid(50, 6'd0), 42, 2'b10);
        issue(st, 2'd0, 1'b1);
        drain("box_up");
    endtask

    task automatic test_blocked();
        logic [133:0] st;
        issue(floor_grid(0, 6'd2), 2'd0, 1'b1); drain("blk_offgrid_up");
        issue(floor_grid(7, 6'd2), 2'd3, 1'b1); drain("blk_offgrid_right");
        st = set_cell(set_cell(floor_grid(9, 6'd2), 10, 2'b10), 11, 2'b01);
        issue(st, 2'd3, 1'b1); drain("blk_box_wall");
        st = set_cell(set_cell(floor_grid(9, 6'd2), 10, 2'b10), 11, 2'b10);
        issue(st, 2'd3, 1'b1); drain("blk_box_box");
        st = set_cell(floor_grid(9, 6'd2), 8, 2'b01);
        issue(st, 2'd2, 1'b1); drain("blk_wall");
        st = set_cell(floor_grid(14, 6'd2), 15, 2'b10);
        issue(st, 2'd3, 1'b1); drain("blk_box_edge");
    endtask

    task automatic test_step_saturate();
        issue(floor_grid(5, 6'd63), 2'd1, 1'b1);
        drain("step_sat");
        checks++;
        if (game_state_mm[133:128] !== 6'd63) begin
            errors++; $display("FAIL step_sat_field: got %0d required 63", game_state_mm[133:128]);
        end
    endtask

    task automatic test_no_player();
        logic [133:0] st;
        st = floor_grid(-1, 6'd5);
        for (int i = 0; i < 64; i += 3) st = set_cell(st, i, 2'b01);
        issue(st, 2'd1, 1'b1);
        drain("no_player");
    endtask

    task automatic test_reset_mid_scan();
        bit strobe;
        issue(floor_grid(40, 6'd0), 2'd3, 1'b0);
        repeat (20) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || game_state_en !== 1'b0 || move_blocked !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_scan: ready=%b en=%b blk=%b sel=%0d required 1/0/0/0", cmd_ready, game_state_en, move_blocked, sel);
        end
        rst = 1'b0;
        exp_mm_prev = '0; exp_bm_prev = '0; exp_win = 1'b0;
        strobe = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (game_state_en || move_blocked) strobe = 1;
        end
        checks++;
        if (strobe !== 1'b0) begin
            errors++; $display("FAIL rst_no_strobe: strobe seen=%b required 0", strobe);
        end
    endtask

    task automatic test_ignore_valid();
        bit strobe;
        fork
            begin
                @(posedge clk); #1;
                cmd_valid = 1'b1; game_state = floor_grid(1, 6'd0); cmd_dir = 2'd1;
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
        join_none
        issue(floor_grid(0, 6'd7), 2'd3, 1'b1);
        drain("ignore_valid");
        strobe = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (game_state_en || move_blocked) strobe = 1;
        end
        checks++;
        if (strobe !== 1'b0) begin
            errors++; $display("FAIL ignore_valid_extra: strobe seen=%b required 0", strobe);
        end
    endtask

    task automatic test_back_to_back();
        logic [133:0] st;
        for (int t = 0; t < 10; t++) begin
            st = '0;
            for (int i = 0; i < 64; i++) st = set_cell(st, i, 2'($urandom_range(0, 2)));
            st = set_cell(st, $urandom_range(0, 63), 2'b11);
            st[133:128] = 6'($urandom_range(0, 63));
            issue(st, 2'($urandom_range(0, 3)), 1'b1);
            drain("b2b");
        end
    endtask

    task automatic test_win();
`ifdef GAME_WIN_DETECT_EN
        logic [133:0] st;
        test_reset();
        goal = 64'h0000_0000_0000_0800;
        issue(floor_grid(0, 6'd0), 2'd3, 1'b1);
        drain("win_man");
        st = set_cell(floor_grid(9, 6'd0), 10, 2'b10);
        issue(st, 2'd3, 1'b1);
        drain("win_box");
        checks++;
        if (win !== 1'b1) begin
            errors++; $display("FAIL win_hold: got %b required 1", win);
        end
`else
        logic [133:0] st;
        st = set_cell(floor_grid(9, 6'd0), 10, 2'b10);
        issue(st, 2'd3, 1'b1);
        drain("win_disabled");
`endif
    endtask

    initial begin
        test_reset();
        test_man_move();
        test_box_push();
        test_blocked();
        test_step_saturate();
        test_no_player();
        test_reset_mid_scan();
        test_ignore_valid();
        test_back_to_back();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
